// File: rtl/mult_ctrl.sv
// rtl/mult_ctrl.sv - shift-add multiplier control FSM (optional macro: MULT_CTRL_ACK_EN)
module mult_ctrl #(
    parameter int SIZE = 32
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic b_lsb,
`ifdef MULT_CTRL_ACK_EN
    input  logic ack,
`endif
    output logic a_sel,
    output logic b_sel,
    output logic prod_sel,
    output logic add_sel,
    output logic enable,
    output logic busy,
    output logic done
);

    // One extra bit so the counter can never wrap inside SIZE iterations.
    localparam int CW = $clog2(SIZE) + 1;
    localparam logic [CW-1:0] lastCnt = CW'(SIZE - 1);
    localparam logic [CW-1:0] oneCnt  = CW'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CALC = 2'd2,
        DONE = 2'd3
    } stateT;

    stateT          state;
    stateT          nextState;
    logic [CW-1:0]  cnt;
    // b_lsb is the LSB B will hold after the edge; lsbQ is the LSB of the current B register.
    logic           lsbQ;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Iteration counter and registered copy of the current B LSB
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt  <= '0;
            lsbQ <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    cnt  <= '0;
                    lsbQ <= b_lsb;
                end
                CALC: begin
                    cnt  <= cnt + oneCnt;
                    lsbQ <= b_lsb;
                end
                default: begin
                    cnt  <= cnt;
                    lsbQ <= lsbQ;
                end
            endcase
        end
    end

    // Next-state logic; start is only looked at in IDLE, so it is never queued
    always_comb begin
        nextState = state;
        case (state)
            IDLE: if (start) nextState = LOAD;
            LOAD: nextState = CALC;
            CALC: if (cnt == lastCnt) nextState = DONE;
            DONE: begin
`ifdef MULT_CTRL_ACK_EN
                if (ack) nextState = IDLE;
`else
                nextState = IDLE;
`endif
            end
            default: nextState = IDLE;
        endcase
    end

    // Output decode from registered state only
    always_comb begin
        a_sel    = 1'b0;
        b_sel    = 1'b0;
        prod_sel = 1'b0;
        add_sel  = 1'b0;
        enable   = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            LOAD: begin
                enable = 1'b1;
                busy   = 1'b1;
            end
            CALC: begin
                a_sel    = 1'b1;
                b_sel    = 1'b1;
                prod_sel = 1'b1;
                add_sel  = lsbQ;
                enable   = 1'b1;
                busy     = 1'b1;
            end
            DONE: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: doc/mult_ctrl.md
Name: mult_ctrl

Overview:
- Control FSM for the shift-add multiplier datapath (operands a32/b, 2N-bit prod).
- Sits directly upstream of the datapath and drives a_sel, b_sel, prod_sel, add_sel and enable.
- Consumes the datapath's b_lsb and runs the load/iterate sequence.
- Handles the start/done handshake with the requesting logic.

Parameters:
SIZE, 32, operand width in bits; equals the number of add/shift iterations.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-low reset.
start  input  1  request a multiply; sampled only in IDLE.
b_lsb  input  1  datapath muxB output bit 0 (combinational next-B LSB).
a_sel  output  1  0 = load a, 1 = shift A left.
b_sel  output  1  0 = load b, 1 = shift B right.
prod_sel  output  1  0 = clear prod, 1 = take add_sel mux result.
add_sel  output  1  0 = hold prod, 1 = prod + A.
enable  output  1  datapath register enable.
busy  output  1  high in LOAD and CALC.
done  output  1  prod valid and final.

Behaviour:
- Mux convention: select 0 passes d1, select 1 passes d2.
- All outputs are decoded from registered state only. There is no combinational path from start or b_lsb to any output.
- Reset (reset=0, async): state=IDLE, cnt=0, lsb_q=0. All outputs 0.
- Reset mid-operation aborts immediately. The datapath is not cleared by this block.
- State IDLE:
  - enable=0, all selects 0, busy=0, done=0.
  - start=1 at a rising edge -> LOAD.
- State LOAD (exactly 1 cycle):
  - enable=1; a_sel=b_sel=prod_sel=0. Datapath loads a and b, and prod is cleared to 0.
  - add_sel=0.
  - Capture lsb_q<=b_lsb (equals b[0]). cnt<=0. -> CALC.
- State CALC (exactly SIZE cycles):
  - enable=1; a_sel=b_sel=prod_sel=1; add_sel=lsb_q.
  - Each edge: lsb_q<=b_lsb (next LSB of shifted B), cnt<=cnt+1.
  - On the edge where cnt==SIZE-1 -> DONE.
- State DONE:
  - enable=0, all selects 0, busy=0, done=1.
  - Default: 1 cycle, then -> IDLE.
- lsb_q is needed because b_lsb reflects the value B will hold after the edge, not the current register. add_sel must use the current B register LSB.
- cnt width is $clog2(SIZE)+1. It must not wrap before SIZE iterations. SIZE=1 is legal: 1 CALC cycle.
- Latency:
  - start sampled at edge E0 -> LOAD in cycle 1, CALC in cycles 2..SIZE+1, done=1 in cycle SIZE+2.
  - prod is final from the start of the DONE cycle and stays stable while enable=0.
- start in LOAD, CALC or DONE is ignored; it is not queued.
- start held high continuously gives back-to-back operations: DONE -> IDLE -> LOAD (one IDLE cycle between operations).

Optional Feature:
- Macro: MULT_CTRL_ACK_EN.
- Defined:
  - Adds input port ack (1 bit).
  - DONE holds done=1, enable=0 until ack=1 at a rising edge, then -> IDLE.
  - ack outside DONE is ignored.
  - ack=1 on the first DONE cycle gives a 1-cycle done.
- Undefined:
  - No ack port; DONE always lasts exactly 1 cycle.

Test Plan:
1. SIZE=32, a32=3, b=5, pulse start for 1 cycle -> busy high for 33 cycles, done=1 on cycle 34 after the start edge, prod=15; done low the next cycle.
2. a32=0xFFFFFFFF, b=0xFFFFFFFF -> prod=0xFFFFFFFE00000001 at done; add_sel=1 on all 32 CALC cycles.
3. b=0x0000000A -> add_sel sequence over CALC is 0,1,0,1 then 28 zeros; prod equals a32*10 for a32=0x12345678 (0xB60B60B0).
4. Assert start again during CALC, and reset=0 for 1 cycle mid-CALC -> start has no effect; on reset all outputs 0 and state IDLE. A new start afterwards completes a 7*9=63 product correctly.
5. start held high for 3 operations with fixed operands 2 and 4 -> done pulses every SIZE+3 cycles, each prod=8.
6. With MULT_CTRL_ACK_EN: hold ack=0 for 10 cycles after done rises -> done stays 1, enable stays 0, prod stable. ack=1 -> IDLE next cycle. Without the macro, done is 1 cycle regardless.
